// File: rtl/aes_model_pack.sv
// Shared AES-128 definitions: data block type, S-box, round constants, round index type.
// Used by the key scheduler and its next-round-key datapath.
// The scheduler state type has an extra replay state when AES_KEY_CACHE_EN is defined.
package aes_model_pack;

  typedef logic [127:0] data_block;
  typedef logic [3:0]   round_idx_t;

  localparam int NUM_AES_ROUNDS = 10;

  localparam logic [7:0] SUB_BYTES_TABLE [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Padded to 16 entries so any 4-bit round index is in range; only 0..9 are used.
  localparam logic [7:0] RCON_TABLE [16] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
    8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };

`ifdef AES_KEY_CACHE_EN
  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_REPLAY} sched_state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_STREAM} sched_state_t;
`endif

endpackage

// File: rtl/aes_next_round_key.sv
// Combinational AES-128 key expansion step: one RotWord/SubWord/Rcon round.
// Ports: key_in (current round key), round_idx (0..9 selects Rcon), key_out (next round key).
// Byte b of a word lives at bits [8b+7:8b]; word j of a key at bits [32j+31:32j].
module aes_next_round_key
  import aes_model_pack::*;
(
  input  data_block  key_in,
  input  round_idx_t round_idx,
  output data_block  key_out
);

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] rot, sub, t;
  logic [31:0] n0, n1, n2, n3;

  assign w0 = key_in[31:0];
  assign w1 = key_in[63:32];
  assign w2 = key_in[95:64];
  assign w3 = key_in[127:96];

  // RotWord: byte1 moves into byte0, ..., byte0 moves into byte3.
  assign rot = {w3[7:0], w3[31:8]};

  always_comb begin
    sub = '0;
    for (int b = 0; b < 4; b++) begin
      sub[8*b +: 8] = SUB_BYTES_TABLE[rot[8*b +: 8]];
    end
  end

  // Rcon only touches byte0.
  assign t  = sub ^ {24'h0, RCON_TABLE[round_idx]};
  assign n0 = w0 ^ t;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  assign key_out = {n3, n2, n1, n0};

endmodule

// File: rtl/aes_key_scheduler.sv
// AES-128 key scheduler: takes a cipher key and streams RK0..RK10 one per rk handshake.
// Ports: clk/rst (sync, active-high); key_valid/key_rdy/key_data in; rk_valid/rk_ready/rk_data/
//   rk_idx/rk_last out; replay_req/cache_valid for the optional schedule cache (macro AES_KEY_CACHE_EN).
module aes_key_scheduler
  import aes_model_pack::*;
#(
  parameter int NUM_ROUNDS = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         key_valid,
  output logic         key_rdy,
  input  logic [127:0] key_data,
  input  logic         replay_req,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] rk_data,
  output logic [3:0]   rk_idx,
  output logic         rk_last,
  output logic         cache_valid
);

  if (NUM_ROUNDS != NUM_AES_ROUNDS) begin : g_bad_rounds
    $error("aes_key_scheduler supports AES-128 (10 rounds) only");
  end

  localparam round_idx_t LAST_M1 = round_idx_t'(NUM_ROUNDS - 1);

  sched_state_t state;
  data_block    next_key;
  logic         beat;

  assign beat = rk_valid && rk_ready;

  aes_next_round_key u_next (
    .key_in    (rk_data),
    .round_idx (rk_idx),
    .key_out   (next_key)
  );

`ifdef AES_KEY_CACHE_EN
  data_block bank [NUM_AES_ROUNDS+1];

  // Bank captures each streamed key as it is handshaken; no reset needed since
  // cache_valid gates every read.
  always_ff @(posedge clk) begin
    if (!rst && state == S_STREAM && beat) begin
      bank[rk_idx] <= rk_data;
    end
  end
`else
  logic unused_replay;
  assign unused_replay = replay_req;
  assign cache_valid   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      key_rdy  <= 1'b1;
      rk_valid <= 1'b0;
      rk_data  <= '0;
      rk_idx   <= '0;
      rk_last  <= 1'b0;
`ifdef AES_KEY_CACHE_EN
      cache_valid <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (key_valid) begin
            state    <= S_STREAM;
            key_rdy  <= 1'b0;
            rk_valid <= 1'b1;
            rk_data  <= key_data;
            rk_idx   <= '0;
            rk_last  <= 1'b0;
`ifdef AES_KEY_CACHE_EN
            cache_valid <= 1'b0;
          end else if (replay_req && cache_valid) begin
            state    <= S_REPLAY;
            key_rdy  <= 1'b0;
            rk_valid <= 1'b1;
            rk_data  <= bank[0];
            rk_idx   <= '0;
            rk_last  <= 1'b0;
`endif
          end
        end
        S_STREAM: begin
          if (beat) begin
            if (rk_last) begin
              // rk_idx and rk_data hold at the final key; key_rdy rises next cycle.
              state    <= S_IDLE;
              rk_valid <= 1'b0;
              rk_last  <= 1'b0;
              key_rdy  <= 1'b1;
`ifdef AES_KEY_CACHE_EN
              cache_valid <= 1'b1;
`endif
            end else begin
              rk_data <= next_key;
              rk_idx  <= rk_idx + 4'd1;
              rk_last <= (rk_idx == LAST_M1);
            end
          end
        end
`ifdef AES_KEY_CACHE_EN
        S_REPLAY: begin
          if (beat) begin
            if (rk_last) begin
              state    <= S_IDLE;
              rk_valid <= 1'b0;
              rk_last  <= 1'b0;
              key_rdy  <= 1'b1;
            end else begin
              rk_data <= bank[rk_idx + 4'd1];
              rk_idx  <= rk_idx + 4'd1;
              rk_last <= (rk_idx == LAST_M1);
            end
          end
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_key_scheduler.sv
// Self-checking bench for aes_key_scheduler: directed sequence with random stalls and random
// keys, checked against a reference key expansion built from GF(2^8) arithmetic.
// Covers AES_KEY_CACHE_EN replay behaviour when the macro is defined.
module tb_aes_key_scheduler;

  logic         clk = 1'b0;
  logic         rst;
  logic         key_valid;
  logic         key_rdy;
  logic [127:0] key_data;
  logic         replay_req;
  logic         rk_valid;
  logic         rk_ready;
  logic [127:0] rk_data;
  logic [3:0]   rk_idx;
  logic         rk_last;
  logic         cache_valid;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] sbox [256];
  logic [7:0] rcon [10];

  localparam logic [127:0] FIPS_KEY  = 128'h3c4fcf09_8815f7ab_a6d2ae28_16157e2b;
  localparam logic [127:0] FIPS_RK1  = 128'h05766c2a_3939a323_b12c5488_17fefaa0;
  localparam logic [127:0] FIPS_RK10 = 128'ha60c63b6_c80c3fe1_8925eec9_a8f914d0;
  localparam logic [127:0] ZERO_RK1  = 128'h63636362_63636362_63636362_63636362;

  aes_key_scheduler #(.NUM_ROUNDS(10)) dut (
    .clk         (clk),
    .rst         (rst),
    .key_valid   (key_valid),
    .key_rdy     (key_rdy),
    .key_data    (key_data),
    .replay_req  (replay_req),
    .rk_valid    (rk_valid),
    .rk_ready    (rk_ready),
    .rk_data     (rk_data),
    .rk_idx      (rk_idx),
    .rk_last     (rk_last),
    .cache_valid (cache_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [15:0] d;
    d = {v, v} << n;
    return d[15:8];
  endfunction

  task automatic build_tables();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
    rcon[0] = 8'h01;
    for (int i = 1; i < 10; i++) rcon[i] = xtime(rcon[i-1]);
  endtask

  // Classic 44-word FIPS-197 expansion, words packed with byte0 in the low bits.
  task automatic expand(input logic [127:0] k, output logic [127:0] rk [11]);
    logic [31:0] w [44];
    logic [31:0] t;
    for (int j = 0; j < 4; j++) w[j] = k[32*j +: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[7:0], t[31:8]};
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {24'h0, rcon[i/4-1]};
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk[r] = {w[4*r+3], w[4*r+2], w[4*r+1], w[4*r]};
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic start_key(input logic [127:0] k);
    int n = 0;
    while (!key_rdy && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check("key_rdy_idle", key_rdy, 1);
    key_valid = 1'b1;
    key_data  = k;
    @(posedge clk); #1;
    key_valid = 1'b0;
  endtask

  // Consumes one 11-beat stream. A stalled beat is re-checked next cycle, so any
  // change of rk_data/rk_idx/rk_last during a stall is caught. Random key_valid
  // pulses during the stream must be ignored.
  task automatic consume(input logic [127:0] exp [11], input int stall_pct,
                         output logic [127:0] got [11], output int cycles);
    int i = 0;
    int budget = 0;
    cycles = 0;
    for (int r = 0; r < 11; r++) got[r] = '0;
    while (i < 11 && budget < 400) begin
      check("rk_valid", rk_valid, 1);
      check("rk_idx", rk_idx, i);
      check("rk_data", rk_data, exp[i]);
      check("rk_last", rk_last, (i == 10));
      check("key_rdy_busy", key_rdy, 0);
      got[i]    = rk_data;
      rk_ready  = ($urandom_range(0, 99) >= stall_pct);
      key_valid = 1'($urandom_range(0, 1));
      key_data  = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk); #1;
      budget++;
      cycles++;
      if (rk_ready) i++;
    end
    rk_ready  = 1'b0;
    key_valid = 1'b0;
    check("stream_timeout", i, 11);
    check("key_rdy_after_last", key_rdy, 1);
    check("rk_valid_after_last", rk_valid, 0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [127:0] exp_a [11];
    logic [127:0] exp_b [11];
    logic [127:0] got [11];
    logic [127:0] k;
    int cyc;
    int n;

    rst = 1'b1; key_valid = 1'b0; key_data = '0; replay_req = 1'b0; rk_ready = 1'b0;
    build_tables();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    check("rst_key_rdy", key_rdy, 1);
    check("rst_rk_valid", rk_valid, 0);
    check("rst_rk_idx", rk_idx, 0);
    check("rst_rk_last", rk_last, 0);
    check("rst_rk_data", rk_data, 0);
    check("rst_cache_valid", cache_valid, 0);

`ifndef AES_KEY_CACHE_EN
    replay_req = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      check("noreplay_rk_valid", rk_valid, 0);
      check("noreplay_cache_valid", cache_valid, 0);
    end
    replay_req = 1'b0;
`endif

    // FIPS key, full throughput: 11 beats on consecutive cycles.
    expand(FIPS_KEY, exp_a);
    start_key(FIPS_KEY);
    consume(exp_a, 0, got, cyc);
    check("fips_cycles", cyc, 11);
    check("fips_rk1", got[1], FIPS_RK1);
    check("fips_rk10", got[10], FIPS_RK10);
    check("fips_rk0", got[0], FIPS_KEY);

`ifdef AES_KEY_CACHE_EN
    check("cache_valid_set", cache_valid, 1);
    replay_req = 1'b1;
    @(posedge clk); #1;
    replay_req = 1'b0;
    consume(exp_a, 30, got, cyc);
    check("replay_rk10", got[10], FIPS_RK10);
    check("cache_valid_after_replay", cache_valid, 1);

    // Key wins over replay when both are offered together.
    k = {$urandom, $urandom, $urandom, $urandom};
    expand(k, exp_b);
    key_valid = 1'b1; replay_req = 1'b1; key_data = k;
    @(posedge clk); #1;
    key_valid = 1'b0; replay_req = 1'b0;
    check("prio_cache_cleared", cache_valid, 0);
    consume(exp_b, 20, got, cyc);
    check("prio_cache_valid", cache_valid, 1);
`endif

    // Same key under random backpressure.
    for (int rep = 0; rep < 2; rep++) begin
      start_key(FIPS_KEY);
      consume(exp_a, 40, got, cyc);
      check("stall_rk10", got[10], FIPS_RK10);
    end

    // Zero key.
    expand('0, exp_b);
    start_key('0);
    consume(exp_b, 25, got, cyc);
    check("zero_rk1", got[1], ZERO_RK1);

    // Random keys.
    for (int rep = 0; rep < 4; rep++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      expand(k, exp_b);
      start_key(k);
      consume(exp_b, 30, got, cyc);
    end

    // Reset in the middle of a stream.
    start_key(FIPS_KEY);
    rk_ready = 1'b1;
    n = 0;
    while (rk_idx != 4'd5 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check("midrst_reached_idx5", rk_idx, 5);
    rk_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_rk_valid", rk_valid, 0);
    check("midrst_key_rdy", key_rdy, 1);
    check("midrst_cache_valid", cache_valid, 0);
    k = {$urandom, $urandom, $urandom, $urandom};
    expand(k, exp_b);
    start_key(k);
    consume(exp_b, 20, got, cyc);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
